// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch address controller: BOOT/REQ/HOLD sequencing, redirect capture while
// memory is busy, sticky misalignment flag and a wrapping count of accepted fetches.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      pc_plus4_i,
  input  logic             branch_i,
  input  logic [31:0]      branch_target_i,
  input  logic             jump_i,
  input  logic [31:0]      jump_target_i,
  input  logic             stall_i,
  input  logic             imem_ack_i,
  output logic [31:0]      pc_o,
  output logic             imem_req_o,
  output logic             instr_valid_o,
  output logic             misalign_o,
  output logic [CNT_W-1:0] fetch_cnt_o,
  output logic [1:0]       state_dbg_o
);

  // Handshake: imem_req_o is held high with pc_o stable until imem_ack_i is seen on a rising
  // edge; that edge accepts the fetch. A request is never withdrawn once raised.
  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             pend_valid_q, pend_valid_d;
  logic [31:0]      pend_addr_q, pend_addr_d;
  logic             instr_valid_q, instr_valid_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             redir_req;
  logic [31:0]      redir_raw;
  logic [31:0]      redir_addr;
  logic             redir_bad;

  // Jump wins over branch; targets are word-aligned before use.
  always_comb begin
    redir_req  = jump_i | branch_i;
    redir_raw  = jump_i ? jump_target_i : branch_target_i;
    redir_addr = {redir_raw[31:2], 2'b00};
    redir_bad  = redir_req & (|redir_raw[1:0]);
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_addr_d   = pend_addr_q;
    instr_valid_d = 1'b0;
    misalign_d    = misalign_q;
    cnt_d         = cnt_q;
    case (state_q)
      S_BOOT: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (imem_ack_i) begin
          instr_valid_d = 1'b1;
          cnt_d         = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          pend_valid_d  = 1'b0;
          if (pend_valid_q) begin
            pc_d = pend_addr_q;
          end else if (redir_req) begin
            pc_d       = redir_addr;
            misalign_d = misalign_q | redir_bad;
          end else begin
            pc_d = pc_plus4_i;
          end
          if (stall_i) state_d = S_HOLD;
        end else if (redir_req) begin
          // Memory busy: remember the newest redirect until the fetch is accepted.
          pend_valid_d = 1'b1;
          pend_addr_d  = redir_addr;
          misalign_d   = misalign_q | redir_bad;
        end
      end
      S_HOLD: begin
        if (redir_req) begin
          pc_d         = redir_addr;
          misalign_d   = misalign_q | redir_bad;
          pend_valid_d = 1'b0;
        end
        if (!stall_i) state_d = S_REQ;
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_addr_q   <= 32'h0;
      instr_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_addr_q   <= pend_addr_d;
      instr_valid_q <= instr_valid_d;
      misalign_q    <= misalign_d;
      cnt_q         <= cnt_d;
    end
  end

  always_comb begin
    pc_o          = pc_q;
    imem_req_o    = (state_q == S_REQ);
    instr_valid_o = instr_valid_q;
    misalign_o    = misalign_q;
    fetch_cnt_o   = cnt_q;
    state_dbg_o   = state_q;
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed vector table, hand-written corner
// sequences, then randomized traffic checked against a behavioural fetch model.
module tb_pc_fetch_ctrl;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_i;
  logic [31:0]      pc_plus4;
  logic             branch_i;
  logic [31:0]      branch_target_i;
  logic             jump_i;
  logic [31:0]      jump_target_i;
  logic             stall_i;
  logic             imem_ack_i;
  logic [31:0]      pc_o;
  logic             imem_req_o;
  logic             instr_valid_o;
  logic             misalign_o;
  logic [CNT_W-1:0] fetch_cnt_o;
  logic [1:0]       state_dbg_o;
  logic [31:0]      plus_off;

  int n_cmp = 0;
  int n_bad = 0;

  // Downstream PC+4 adder fed by pc_o; plus_off lets the bench feed odd values too.
  assign pc_plus4 = pc_o + plus_off;

  pc_fetch_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .pc_plus4_i     (pc_plus4),
    .branch_i       (branch_i),
    .branch_target_i(branch_target_i),
    .jump_i         (jump_i),
    .jump_target_i  (jump_target_i),
    .stall_i        (stall_i),
    .imem_ack_i     (imem_ack_i),
    .pc_o           (pc_o),
    .imem_req_o     (imem_req_o),
    .instr_valid_o  (instr_valid_o),
    .misalign_o     (misalign_o),
    .fetch_cnt_o    (fetch_cnt_o),
    .state_dbg_o    (state_dbg_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: phase is "booting", "fetching" or "paused".
  typedef enum int {PH_BOOTING, PH_FETCHING, PH_PAUSED} phase_t;
  phase_t      m_phase;
  logic [31:0] m_pc;
  logic [31:0] m_pend[$];
  bit          m_valid;
  bit          m_mis;
  int          m_cnt;

  task automatic model_reset();
    m_phase = PH_BOOTING;
    m_pc    = 32'h0;
    m_pend.delete();
    m_valid = 0;
    m_mis   = 0;
    m_cnt   = 0;
  endtask

  // Applies one clock's worth of the fetch rules to the model, using the current inputs.
  task automatic model_step();
    bit          has_tgt;
    logic [31:0] tgt;
    has_tgt = jump_i || branch_i;
    tgt     = jump_i ? jump_target_i : branch_target_i;
    m_valid = 0;
    if (m_phase == PH_BOOTING) begin
      m_phase = PH_FETCHING;
    end else if (m_phase == PH_FETCHING) begin
      if (imem_ack_i) begin
        if (m_pend.size() > 0) begin
          m_pc = m_pend.pop_front();
        end else if (has_tgt) begin
          m_pc  = tgt & 32'hFFFF_FFFC;
          m_mis = m_mis || (tgt % 4 != 0);
        end else begin
          m_pc = m_pc + plus_off;
        end
        m_pend.delete();
        m_valid = 1;
        m_cnt   = (m_cnt + 1) % (1 << CNT_W);
        if (stall_i) m_phase = PH_PAUSED;
      end else if (has_tgt) begin
        m_pend.delete();
        m_pend.push_back(tgt & 32'hFFFF_FFFC);
        m_mis = m_mis || (tgt % 4 != 0);
      end
    end else begin
      if (has_tgt) begin
        m_pc  = tgt & 32'hFFFF_FFFC;
        m_mis = m_mis || (tgt % 4 != 0);
        m_pend.delete();
      end
      if (!stall_i) m_phase = PH_FETCHING;
    end
  endtask

  // Scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("pc",    pc_o, m_pc);
    check("req",   {31'b0, imem_req_o}, {31'b0, m_phase == PH_FETCHING});
    check("valid", {31'b0, instr_valid_o}, {31'b0, m_valid});
    check("mis",   {31'b0, misalign_o}, {31'b0, m_mis});
    check("cnt",   {28'b0, fetch_cnt_o}, m_cnt);
  endtask

  // Driver: inputs are already set; advance one edge and compare #1 after it.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic drive(input bit j, input logic [31:0] jt, input bit b, input logic [31:0] bt,
                       input bit st, input bit ack);
    jump_i          = j;
    jump_target_i   = jt;
    branch_i        = b;
    branch_target_i = bt;
    stall_i         = st;
    imem_ack_i      = ack;
  endtask

  typedef struct {
    bit          j;
    logic [31:0] jt;
    bit          b;
    logic [31:0] bt;
    bit          st;
    bit          ack;
    logic [31:0] e_pc;
    bit          e_req;
    bit          e_val;
    bit          e_mis;
    int          e_cnt;
  } vec_t;

  vec_t vecs[17];

  initial begin
    //          j  jt            b  bt           st ack e_pc          req val mis cnt
    vecs[0]  = '{0, 32'h0,       0, 32'h0,       0, 1, 32'h0000_0000, 1, 0, 0, 0};
    vecs[1]  = '{0, 32'h0,       0, 32'h0,       0, 1, 32'h0000_0004, 1, 1, 0, 1};
    vecs[2]  = '{0, 32'h0,       0, 32'h0,       0, 1, 32'h0000_0008, 1, 1, 0, 2};
    vecs[3]  = '{0, 32'h0,       0, 32'h0,       0, 1, 32'h0000_000C, 1, 1, 0, 3};
    vecs[4]  = '{1, 32'h8,       0, 32'h0,       0, 1, 32'h0000_0008, 1, 1, 0, 4};
    vecs[5]  = '{0, 32'h0,       1, 32'h40,      0, 1, 32'h0000_0040, 1, 1, 0, 5};
    vecs[6]  = '{1, 32'h100,     0, 32'h0,       0, 0, 32'h0000_0040, 1, 0, 0, 5};
    vecs[7]  = '{0, 32'h0,       1, 32'h80,      0, 0, 32'h0000_0040, 1, 0, 0, 5};
    vecs[8]  = '{0, 32'h0,       0, 32'h0,       1, 0, 32'h0000_0040, 1, 0, 0, 5};
    vecs[9]  = '{0, 32'h0,       0, 32'h0,       0, 1, 32'h0000_0080, 1, 1, 0, 6};
    vecs[10] = '{0, 32'h0,       0, 32'h0,       0, 1, 32'h0000_0084, 1, 1, 0, 7};
    vecs[11] = '{1, 32'h10,      0, 32'h0,       0, 1, 32'h0000_0010, 1, 1, 0, 8};
    vecs[12] = '{0, 32'h0,       0, 32'h0,       1, 1, 32'h0000_0014, 0, 1, 0, 9};
    vecs[13] = '{0, 32'h0,       0, 32'h0,       1, 1, 32'h0000_0014, 0, 0, 0, 9};
    vecs[14] = '{1, 32'h203,     0, 32'h0,       1, 0, 32'h0000_0200, 0, 0, 1, 9};
    vecs[15] = '{0, 32'h0,       0, 32'h0,       0, 0, 32'h0000_0200, 1, 0, 1, 9};
    vecs[16] = '{0, 32'h0,       0, 32'h0,       0, 1, 32'h0000_0204, 1, 1, 1, 10};
  end

  initial begin
    rst_i    = 1'b0;
    plus_off = 32'd4;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_model();
    rst_i = 1'b1;
    #1;
    check("boot_req", {31'b0, imem_req_o}, 32'd0);

    // Directed table: sequential fetch, redirects, pending capture, stall/HOLD, misalign.
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].j, vecs[i].jt, vecs[i].b, vecs[i].bt, vecs[i].st, vecs[i].ack);
      step();
      check($sformatf("tbl%0d_pc", i), pc_o, vecs[i].e_pc);
      check($sformatf("tbl%0d_req", i), {31'b0, imem_req_o}, {31'b0, vecs[i].e_req});
      check($sformatf("tbl%0d_val", i), {31'b0, instr_valid_o}, {31'b0, vecs[i].e_val});
      check($sformatf("tbl%0d_mis", i), {31'b0, misalign_o}, {31'b0, vecs[i].e_mis});
      check($sformatf("tbl%0d_cnt", i), {28'b0, fetch_cnt_o}, vecs[i].e_cnt);
    end

    // Address wrap past 2^32 and fetch counter wrap from 15 to 0.
    drive(1, 32'hFFFF_FFFC, 0, 0, 0, 1);
    step();
    check("wrap_pc_top", pc_o, 32'hFFFF_FFFC);
    drive(0, 0, 0, 0, 0, 1);
    step();
    check("wrap_pc_zero", pc_o, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("cnt_wrap%0d", i), {28'b0, fetch_cnt_o}, (13 + i) % 16);
    end
    check("cnt_wrapped", {28'b0, fetch_cnt_o}, 32'd0);

    // Asynchronous reset in the middle of an acknowledged request.
    drive(0, 0, 0, 0, 0, 1);
    @(posedge clk);
    #3;
    rst_i = 1'b0;
    #1;
    model_reset();
    check("arst_pc",    pc_o, 32'h0);
    check("arst_req",   {31'b0, imem_req_o}, 32'd0);
    check("arst_valid", {31'b0, instr_valid_o}, 32'd0);
    check("arst_mis",   {31'b0, misalign_o}, 32'd0);
    check("arst_cnt",   {28'b0, fetch_cnt_o}, 32'd0);
    @(posedge clk);
    #1;
    check("arst_edge_valid", {31'b0, instr_valid_o}, 32'd0);
    check("arst_edge_cnt",   {28'b0, fetch_cnt_o}, 32'd0);
    rst_i = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 5) == 0, $urandom,
            $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 6);
      if ($urandom_range(0, 3) == 0) begin
        jump_target_i   = jump_target_i & 32'hFFFF_FFFC;
        branch_target_i = branch_target_i & 32'hFFFF_FFFC;
      end
      plus_off = ($urandom_range(0, 9) == 0) ? $urandom : 32'd4;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
